// File: rtl/gpu_tri_scan_ctrl.sv
// Triangle scan sequencer: places the pixel scanner at the bounding-box
// origin, walks each scanline in serpentine order two pixels at a time and
// hands every inside pair to the pixel pipeline over a valid/ready handshake.
// Scanner strobes are decoded combinationally from the state and inputs so a
// pair can be accepted and the scanner advanced in the same cycle.
module gpu_tri_scan_ctrl (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [11:0] i_minTriX,
    input  logic [11:0] i_maxTriX,
    input  logic [11:0] i_maxTriY,
    input  logic [11:0] i_pixelX,
    input  logic [11:0] i_nextLineY,
    input  logic        i_pairInside,
    input  logic        i_dir,
    input  logic        i_pixelFound,
    input  logic        i_completedOneDir,
    output logic        o_loadNext,
    output logic [2:0]  o_selNextX,
    output logic [2:0]  o_selNextY,
    output logic        o_resetDir,
    output logic        o_switchDir,
    output logic        o_setPixelFound,
    output logic        o_setDirComplete,
    output logic        o_resetPixelFound,
    output logic        o_pairValid,
    input  logic        i_pairReady,
    output logic        o_busy,
    output logic        o_done
);

    localparam logic [2:0] X_ASIS       = 3'd0;
    localparam logic [2:0] X_TRI_NEXT   = 3'd1;
    localparam logic [2:0] X_TRI_BBLEFT = 3'd4;
    localparam logic [2:0] Y_ASIS       = 3'd0;
    localparam logic [2:0] Y_TRI_START  = 3'd3;
    localparam logic [2:0] Y_TRI_NEXT   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_SETTLE   = 3'd2,
        S_SCAN     = 3'd3,
        S_NEXTLINE = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t state_q;
    state_t state_d;

    // Pair coordinates: bit 0 selects the pixel inside a pair and is ignored.
    logic signed [10:0] px_pair_s;
    logic signed [10:0] min_pair_s;
    logic signed [10:0] max_pair_s;
    logic               at_edge_s;
    logic               last_line_s;

    logic       load_s;
    logic [2:0] sel_x_s;
    logic [2:0] sel_y_s;
    logic       reset_dir_s;
    logic       switch_dir_s;
    logic       set_found_s;
    logic       set_dir_done_s;
    logic       reset_found_s;
    logic       pair_valid_s;

    assign px_pair_s   = i_pixelX[11:1];
    assign min_pair_s  = i_minTriX[11:1];
    assign max_pair_s  = i_maxTriX[11:1];
    assign at_edge_s   = i_dir ? (px_pair_s <= min_pair_s) : (px_pair_s >= max_pair_s);
    assign last_line_s = ($signed(i_nextLineY) > $signed(i_maxTriY));

    // Next-state and scanner strobe decode; abort overrides everything.
    always_comb begin
        state_d        = state_q;
        load_s         = 1'b0;
        sel_x_s        = X_ASIS;
        sel_y_s        = Y_ASIS;
        reset_dir_s    = 1'b0;
        switch_dir_s   = 1'b0;
        set_found_s    = 1'b0;
        set_dir_done_s = 1'b0;
        reset_found_s  = 1'b0;
        pair_valid_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    reset_dir_s = 1'b1;
                    load_s      = 1'b1;
                    sel_x_s     = X_TRI_BBLEFT;
                    sel_y_s     = Y_TRI_START;
                    state_d     = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START:  state_d = S_SETTLE;
            S_SETTLE: state_d = S_SCAN;
            S_SCAN: begin
                if (i_pairInside) begin
                    pair_valid_s = 1'b1;
                    if (i_pairReady) begin
                        set_found_s = 1'b1;
                        if (at_edge_s) begin
                            state_d = S_NEXTLINE;
                        end else begin
                            load_s  = 1'b1;
                            sel_x_s = X_TRI_NEXT;
                        end
                    end else begin
                        state_d = S_SCAN;
                    end
                end else if (i_pixelFound) begin
                    state_d = S_NEXTLINE;
                end else if (!at_edge_s) begin
                    load_s  = 1'b1;
                    sel_x_s = X_TRI_NEXT;
                end else if (!i_completedOneDir) begin
                    // Nothing seen yet: re-walk this line the other way.
                    set_dir_done_s = 1'b1;
                    switch_dir_s   = 1'b1;
                    state_d        = S_SETTLE;
                end else begin
                    state_d = S_NEXTLINE;
                end
            end
            S_NEXTLINE: begin
                if (last_line_s) begin
                    state_d = S_DONE;
                end else begin
                    // Keep X and reverse direction for serpentine order.
                    load_s        = 1'b1;
                    sel_y_s       = Y_TRI_NEXT;
                    switch_dir_s  = 1'b1;
                    reset_found_s = 1'b1;
                    state_d       = S_SETTLE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (i_abort) begin
            state_d        = S_IDLE;
            load_s         = 1'b0;
            sel_x_s        = X_ASIS;
            sel_y_s        = Y_ASIS;
            reset_dir_s    = 1'b0;
            switch_dir_s   = 1'b0;
            set_found_s    = 1'b0;
            set_dir_done_s = 1'b0;
            reset_found_s  = 1'b0;
            pair_valid_s   = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign o_loadNext        = load_s;
    assign o_selNextX        = sel_x_s;
    assign o_selNextY        = sel_y_s;
    assign o_resetDir        = reset_dir_s;
    assign o_switchDir       = switch_dir_s;
    assign o_setPixelFound   = set_found_s;
    assign o_setDirComplete  = set_dir_done_s;
    assign o_resetPixelFound = reset_found_s;
    assign o_pairValid       = pair_valid_s;
    assign o_busy            = (state_q != S_IDLE);
    assign o_done            = (state_q == S_DONE);

endmodule

// File: tb/tb_gpu_tri_scan_ctrl.sv
// Bench for gpu_tri_scan_ctrl: a small scanner model answers the strobes,
// each scanline's inside region is a contiguous run of pairs, and the
// expected pair order is derived line by line from the run position.
module tb_gpu_tri_scan_ctrl;

    logic        i_clk = 1'b0;
    logic        i_nrst, i_start, i_abort, i_pairReady;
    logic [11:0] i_minTriX, i_maxTriX, i_maxTriY, i_pixelX, i_nextLineY;
    logic        i_pairInside, i_dir, i_pixelFound, i_completedOneDir;
    logic        o_loadNext, o_resetDir, o_switchDir, o_setPixelFound;
    logic        o_setDirComplete, o_resetPixelFound, o_pairValid, o_busy, o_done;
    logic [2:0]  o_selNextX, o_selNextY;

    int errors = 0;
    int checks = 0;

    // scanner model state
    logic signed [11:0] sc_x, sc_y;
    logic               sc_dir, sc_found, sc_comp;
    logic [4:0]         sc_li;
    int box_min, box_max, box_maxy, start_y, line_inc;
    int run_a [32];
    int run_b [32];
    bit run_e [32];

    int exp_x[$], exp_y[$], act_x[$], act_y[$];
    int exp_rev;

    always #5 i_clk = ~i_clk;

    gpu_tri_scan_ctrl dut (
        .i_clk(i_clk), .i_nrst(i_nrst), .i_start(i_start), .i_abort(i_abort),
        .i_minTriX(i_minTriX), .i_maxTriX(i_maxTriX), .i_maxTriY(i_maxTriY),
        .i_pixelX(i_pixelX), .i_nextLineY(i_nextLineY), .i_pairInside(i_pairInside),
        .i_dir(i_dir), .i_pixelFound(i_pixelFound), .i_completedOneDir(i_completedOneDir),
        .o_loadNext(o_loadNext), .o_selNextX(o_selNextX), .o_selNextY(o_selNextY),
        .o_resetDir(o_resetDir), .o_switchDir(o_switchDir), .o_setPixelFound(o_setPixelFound),
        .o_setDirComplete(o_setDirComplete), .o_resetPixelFound(o_resetPixelFound),
        .o_pairValid(o_pairValid), .i_pairReady(i_pairReady), .o_busy(o_busy), .o_done(o_done)
    );

    assign i_pixelX          = sc_x;
    assign i_nextLineY       = 12'(int'(sc_y) + line_inc);
    assign i_dir             = sc_dir;
    assign i_pixelFound      = sc_found;
    assign i_completedOneDir = sc_comp;
    assign i_pairInside      = !run_e[sc_li] && (int'(sc_x) >= run_a[sc_li]) && (int'(sc_x) <= run_b[sc_li]);

    // scanner model reacting to the controller strobes
    always @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            sc_x <= '0; sc_y <= '0; sc_dir <= 1'b0; sc_found <= 1'b0; sc_comp <= 1'b0; sc_li <= '0;
        end else begin
            if (o_loadNext) begin
                if (o_selNextX == 3'd4) sc_x <= 12'(box_min);
                else if (o_selNextX == 3'd1) sc_x <= sc_dir ? sc_x - 12'sd2 : sc_x + 12'sd2;
                if (o_selNextY == 3'd3) begin
                    sc_y <= 12'(start_y); sc_li <= '0; sc_found <= 1'b0; sc_comp <= 1'b0;
                end else if (o_selNextY == 3'd4) begin
                    sc_y <= 12'(int'(sc_y) + line_inc); sc_li <= sc_li + 5'd1;
                end
            end
            if (o_resetDir)        sc_dir <= 1'b0;
            if (o_switchDir)       sc_dir <= ~sc_dir;
            if (o_setPixelFound)   sc_found <= 1'b1;
            if (o_setDirComplete)  sc_comp <= 1'b1;
            if (o_resetPixelFound) begin sc_found <= 1'b0; sc_comp <= 1'b0; end
        end
    end

    // Expected visit of one line given the run and where the scanner stands.
    task automatic model_line(input int li, input int y, inout int x, inout int d);
        int a = run_a[li];
        int b = run_b[li];
        if (run_e[li]) begin
            exp_rev++;
            x = (d == 0) ? box_min : box_max;
        end else if ((d == 0 && x <= b) || (d == 1 && x >= a)) begin
            if (d == 0) begin
                for (int k = (x > a ? x : a); k <= b; k += 2) begin exp_x.push_back(k); exp_y.push_back(y); end
                x = (b == box_max) ? b : b + 2;
                d = 1;
            end else begin
                for (int k = (x < b ? x : b); k >= a; k -= 2) begin exp_x.push_back(k); exp_y.push_back(y); end
                x = (a == box_min) ? a : a - 2;
                d = 0;
            end
        end else begin
            exp_rev++;
            if (d == 0) begin
                for (int k = b; k >= a; k -= 2) begin exp_x.push_back(k); exp_y.push_back(y); end
                x = (a == box_min) ? a : a - 2;
            end else begin
                for (int k = a; k <= b; k += 2) begin exp_x.push_back(k); exp_y.push_back(y); end
                x = (b == box_max) ? b : b + 2;
            end
        end
    endtask

    task automatic model_tri();
        int x = box_min;
        int d = 0;
        int y = start_y;
        exp_x.delete(); exp_y.delete(); exp_rev = 0;
        for (int li = 0; li < 32; li++) begin
            model_line(li, y, x, d);
            if (y + line_inc > box_maxy) break;
            y += line_inc;
        end
    endtask

    task automatic run_tri(input string name, input int mnx, input int mxx, input int sy, input int my,
                           input int inc, input int stall_idx, input int stall_len, input int rdy_pct,
                           input bit start_mid, input bit odd_lsb);
        int done_cnt = 0, rev_cnt = 0, held = 0, stall_cnt = 0;
        bit prev_stall = 1'b0, fin = 1'b0;
        logic signed [11:0] px, py;
        int n;
        px = '0; py = '0;
        box_min = mnx; box_max = mxx; start_y = sy; box_maxy = my; line_inc = inc;
        i_minTriX = 12'(mnx + (odd_lsb ? 1 : 0));
        i_maxTriX = 12'(mxx + (odd_lsb ? 1 : 0));
        i_maxTriY = 12'(my);
        model_tri();
        act_x.delete(); act_y.delete();
        @(negedge i_clk); i_start = 1'b1; i_pairReady = 1'b0;
        @(negedge i_clk); i_start = 1'b0; #1;
        checks++;
        if (o_busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_start: got %b need 1", name, o_busy); end
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            @(negedge i_clk);
            i_start = (start_mid && cyc == 6);
            if (o_pairValid && int'(act_x.size()) == stall_idx && stall_cnt < stall_len) begin
                i_pairReady = 1'b0; stall_cnt++;
            end else begin
                i_pairReady = (int'($urandom_range(99)) < rdy_pct);
            end
            #1;
            if (prev_stall) begin
                checks++;
                if (o_pairValid !== 1'b1 || sc_x !== px || sc_y !== py) begin
                    errors++;
                    $display("FAIL %s stall_hold: valid=%b pos=(%0d,%0d) need valid=1 pos=(%0d,%0d)",
                             name, o_pairValid, sc_x, sc_y, px, py);
                end
            end
            prev_stall = 1'b0;
            if (o_done) done_cnt++;
            if (o_setDirComplete) begin
                rev_cnt++;
                checks++;
                if (o_switchDir !== 1'b1) begin errors++; $display("FAIL %s reverse_switch: got %b need 1", name, o_switchDir); end
            end
            if (o_pairValid) begin
                if (int'(act_x.size()) == stall_idx) held++;
                if (i_pairReady) begin
                    act_x.push_back(int'(sc_x)); act_y.push_back(int'(sc_y));
                end else begin
                    checks++;
                    if (o_loadNext !== 1'b0) begin errors++; $display("FAIL %s stall_load: got %b need 0", name, o_loadNext); end
                    prev_stall = 1'b1; px = sc_x; py = sc_y;
                end
            end
            if (!o_busy) fin = 1'b1;
        end
        i_start = 1'b0;
        checks++;
        if (!fin) begin errors++; $display("FAIL %s timeout: busy still %b need 0", name, o_busy); end
        checks++;
        if (act_x.size() != exp_x.size()) begin
            errors++; $display("FAIL %s pair_count: got %0d need %0d", name, act_x.size(), exp_x.size());
        end
        n = (act_x.size() < exp_x.size()) ? act_x.size() : exp_x.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (act_x[i] != exp_x[i] || act_y[i] != exp_y[i]) begin
                errors++;
                $display("FAIL %s pair[%0d]: got (%0d,%0d) need (%0d,%0d)", name, i, act_x[i], act_y[i], exp_x[i], exp_y[i]);
            end
        end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL %s done_pulses: got %0d need 1", name, done_cnt); end
        checks++;
        if (rev_cnt != exp_rev) begin errors++; $display("FAIL %s reversals: got %0d need %0d", name, rev_cnt, exp_rev); end
        if (stall_len > 0) begin
            checks++;
            if (held != stall_len + 1) begin errors++; $display("FAIL %s valid_held: got %0d need %0d", name, held, stall_len + 1); end
        end
    endtask

    task automatic fill_runs(input int a, input int b);
        for (int i = 0; i < 32; i++) begin run_a[i] = a; run_b[i] = b; run_e[i] = 1'b0; end
    endtask

    task automatic test_reset();
        i_nrst = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_pairReady = 1'b0;
        i_minTriX = '0; i_maxTriX = '0; i_maxTriY = '0;
        line_inc = 1; box_min = 0; box_max = 0; start_y = 0; box_maxy = 0;
        fill_runs(0, 6);
        #12;
        checks++;
        if ({o_busy, o_done, o_pairValid, o_loadNext, o_resetDir, o_switchDir, o_setPixelFound,
             o_setDirComplete, o_resetPixelFound} !== 9'd0 || o_selNextX !== 3'd0 || o_selNextY !== 3'd0) begin
            errors++; $display("FAIL reset_values: busy=%b done=%b valid=%b load=%b selx=%0d sely=%0d need all 0",
                               o_busy, o_done, o_pairValid, o_loadNext, o_selNextX, o_selNextY);
        end
        @(negedge i_clk); i_nrst = 1'b1;
        // reset again in the middle of a scan
        i_minTriX = 12'd0; i_maxTriX = 12'd6; i_maxTriY = 12'd1; box_max = 6; box_maxy = 1;
        @(negedge i_clk); i_start = 1'b1;
        @(negedge i_clk); i_start = 1'b0; i_pairReady = 1'b0;
        repeat (3) @(negedge i_clk);
        #1;
        checks++;
        if (o_pairValid !== 1'b1) begin errors++; $display("FAIL reset_pre_valid: got %b need 1", o_pairValid); end
        #1 i_nrst = 1'b0;
        #1;
        checks++;
        if (o_pairValid !== 1'b0 || o_busy !== 1'b0 || o_selNextX !== 3'd0 || o_selNextY !== 3'd0 || o_loadNext !== 1'b0) begin
            errors++; $display("FAIL reset_mid_scan: valid=%b busy=%b selx=%0d sely=%0d load=%b need 0",
                               o_pairValid, o_busy, o_selNextX, o_selNextY, o_loadNext);
        end
        @(negedge i_clk); i_nrst = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic test_full_box();
        fill_runs(0, 6);
        run_tri("full_box", 0, 6, 0, 1, 1, -1, 0, 100, 1'b1, 1'b0);
        checks++;
        if (exp_x.size() != 8) begin errors++; $display("FAIL full_box_model_count: got %0d need 8", exp_x.size()); end
    endtask

    task automatic test_backpressure();
        fill_runs(0, 6);
        run_tri("backpressure", 0, 6, 0, 1, 1, 1, 3, 100, 1'b0, 1'b0);
    endtask

    task automatic test_reversal();
        fill_runs(0, 2);
        run_a[1] = 6; run_b[1] = 8;
        run_tri("reversal", 0, 8, 0, 1, 1, -1, 0, 100, 1'b0, 1'b0);
    endtask

    task automatic test_empty_line();
        fill_runs(2, 4);
        run_e[0] = 1'b1;
        run_tri("empty_line", 0, 6, 0, 1, 1, -1, 0, 100, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        bit seen = 1'b0;
        fill_runs(0, 6);
        box_min = 0; box_max = 6; start_y = 0; box_maxy = 1; line_inc = 1;
        i_minTriX = 12'd0; i_maxTriX = 12'd6; i_maxTriY = 12'd1;
        @(negedge i_clk); i_start = 1'b1; i_pairReady = 1'b0;
        @(negedge i_clk); i_start = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge i_clk); #1;
            if (o_pairValid) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL abort_wait_valid: got 0 need 1"); end
        @(negedge i_clk); i_abort = 1'b1; #1;
        checks++;
        if (o_loadNext !== 1'b0 || o_setPixelFound !== 1'b0 || o_switchDir !== 1'b0) begin
            errors++; $display("FAIL abort_strobes: load=%b spf=%b sw=%b need 0", o_loadNext, o_setPixelFound, o_switchDir);
        end
        @(negedge i_clk); i_abort = 1'b0; #1;
        checks++;
        if (o_busy !== 1'b0 || o_pairValid !== 1'b0 || o_done !== 1'b0) begin
            errors++; $display("FAIL abort_idle: busy=%b valid=%b done=%b need 0", o_busy, o_pairValid, o_done);
        end
        repeat (3) begin
            @(negedge i_clk); #1;
            checks++;
            if (o_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b need 0", o_done); end
        end
        run_tri("after_abort", 0, 6, 0, 1, 1, -1, 0, 100, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            int mnx = 2 * int'($urandom_range(16)) - 16;
            int w   = 2 * int'($urandom_range(6));
            int inc = 1 + int'($urandom_range(1));
            int nl  = 1 + int'($urandom_range(4));
            int sy  = int'($urandom_range(20)) - 10;
            int my  = sy + inc * (nl - 1) + int'($urandom_range(inc - 1));
            for (int li = 0; li < 32; li++) begin
                run_e[li] = ($urandom_range(3) == 0);
                run_a[li] = mnx + 2 * int'($urandom_range(w / 2));
                run_b[li] = run_a[li] + 2 * int'($urandom_range((mnx + w - run_a[li]) / 2));
            end
            run_tri("random", mnx, mnx + w, sy, my, inc, -1, 0, 40 + int'($urandom_range(60)), 1'b0,
                    1'($urandom_range(1)));
        end
    endtask

    initial begin
        test_reset();
        test_full_box();
        test_backpressure();
        test_reversal();
        test_empty_line();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
